// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared register offsets, CTRL bit positions and FSM states
package sys_bus_pkg;

  // Word offsets within the 20-bit register window
  localparam logic [19:0] OFF_CFG0 = 20'h00;
  localparam logic [19:0] OFF_CFG1 = 20'h04;
  localparam logic [19:0] OFF_CFG2 = 20'h08;
  localparam logic [19:0] OFF_CFG3 = 20'h0C;
  localparam logic [19:0] OFF_ID   = 20'h10;
  localparam logic [19:0] OFF_WCNT = 20'h14;
  localparam logic [19:0] OFF_RCNT = 20'h18;
  localparam logic [19:0] OFF_CTRL = 20'h1C;
  localparam logic [19:0] OFF_END  = 20'h20;

  // CTRL bits: bit0 is a write-only counter clear, bit1 the sticky overrun flag
  localparam int CTRL_CLR_CNT = 0;
  localparam int CTRL_OVERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Latched request kind; REQ_BAD marks a simultaneous read and write
  typedef enum logic [1:0] {
    REQ_WR,
    REQ_RD,
    REQ_BAD
  } req_t;

endpackage

// File: rtl/sys_bus_wait_cnt.sv
// rtl/sys_bus_wait_cnt.sv - 4-bit load/decrement counter timing the WAIT state
module sys_bus_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  // Load on request acceptance, count down once per WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The cycle holding count 1 is the last WAIT cycle
  assign done = (cnt <= 4'd1);

endmodule

// File: rtl/sys_bus_responder.sv
// rtl/sys_bus_responder.sv - register-file responder on a pulse-request system bus
module sys_bus_responder
  import sys_bus_pkg::*;
#(
  parameter int          AXI_DW  = 32,
  parameter int          AXI_AW  = 32,
  parameter int          AXI_SW  = AXI_DW >> 3,
  parameter int          ACK_LAT = 0,
  parameter logic [31:0] ID_VAL  = 32'h0001_0000
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [AXI_AW-1:0]   sys_addr_i,
  input  logic [AXI_DW-1:0]   sys_wdata_i,
  input  logic [AXI_SW-1:0]   sys_sel_i,
  input  logic                sys_wen_i,
  input  logic                sys_ren_i,
  output logic [AXI_DW-1:0]   sys_rdata_o,
  output logic                sys_err_o,
  output logic                sys_ack_o,
  output logic [4*AXI_DW-1:0] cfg_o
);

  state_t                  state;
  req_t                    kind_q;
  logic [19:0]             off_q;
  logic [AXI_DW-1:0]       wdata_q;
  logic [AXI_SW-1:0]       sel_q;
  logic [3:0][AXI_DW-1:0]  cfg;
  logic [31:0]             wcnt;
  logic [31:0]             rcnt;
  logic                    overrun;
  logic                    req_any;
  logic                    bad;
  logic                    wait_done;
  logic [AXI_DW-1:0]       rd_val;
  logic [31:0]             ctrl_rd;
  logic                    unused_addr_hi;

  assign req_any        = sys_wen_i | sys_ren_i;
  assign bad            = (kind_q == REQ_BAD) || (off_q[1:0] != 2'b00) || (off_q >= OFF_END);
  assign cfg_o          = cfg;
  assign unused_addr_hi = ^sys_addr_i[AXI_AW-1:20];

  sys_bus_wait_cnt u_wait_cnt (
    .clk      (sys_clk_i),
    .rst      (sys_rst_i),
    .load     ((state == ST_IDLE) && req_any),
    .load_val (4'(ACK_LAT)),
    .dec      (state == ST_WAIT),
    .done     (wait_done)
  );

  // Read mux over the latched offset
  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_OVERRUN] = overrun;
    rd_val                = '0;
    case (off_q)
      OFF_CFG0, OFF_CFG1, OFF_CFG2, OFF_CFG3: rd_val = cfg[off_q[3:2]];
      OFF_ID:   rd_val = AXI_DW'(ID_VAL);
      OFF_WCNT: rd_val = AXI_DW'(wcnt);
      OFF_RCNT: rd_val = AXI_DW'(rcnt);
      OFF_CTRL: rd_val = AXI_DW'(ctrl_rd);
      default:  rd_val = '0;
    endcase
  end

  // Request FSM with registered response and all register-file state
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state       <= ST_IDLE;
      kind_q      <= REQ_RD;
      off_q       <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;
      cfg         <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      overrun     <= 1'b0;
    end else begin
      sys_ack_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_any) begin
            off_q   <= sys_addr_i[19:0];
            wdata_q <= sys_wdata_i;
            sel_q   <= sys_sel_i;
            kind_q  <= (sys_wen_i && sys_ren_i) ? REQ_BAD : (sys_wen_i ? REQ_WR : REQ_RD);
            state   <= (ACK_LAT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_done) state <= ST_RESP;
        end
        ST_RESP: begin
          sys_ack_o   <= 1'b1;
          sys_err_o   <= bad;
          sys_rdata_o <= (!bad && kind_q == REQ_RD) ? rd_val : '0;
          state       <= ST_IDLE;
          if (!bad && kind_q == REQ_RD) rcnt <= rcnt + 32'd1;
          if (!bad && kind_q == REQ_WR) begin
            wcnt <= wcnt + 32'd1;
            case (off_q)
              OFF_CFG0, OFF_CFG1, OFF_CFG2, OFF_CFG3: begin
                for (int b = 0; b < AXI_SW; b++) begin
                  if (sel_q[b]) cfg[off_q[3:2]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
              end
              OFF_CTRL: begin
                // The CTRL write itself is counted after the clear
                if (wdata_q[CTRL_CLR_CNT]) begin
                  wcnt <= 32'd1;
                  rcnt <= 32'd0;
                end
                if (wdata_q[CTRL_OVERRUN]) overrun <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A request outside IDLE is dropped; flagging it takes priority over a clear
      if ((state != ST_IDLE) && req_any) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_bus_responder.sv
// tb/tb_sys_bus_responder.sv - scoreboard bench for sys_bus_responder at ACK_LAT 0, 3 and 5
module tb_sys_bus_responder;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [3:0]   sel = '0;
  logic [2:0]   wen = '0;
  logic [2:0]   ren = '0;
  logic [31:0]  rdata [3];
  logic [2:0]   err;
  logic [2:0]   ack;
  logic [127:0] cfg [3];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  rsp_t mon_r;

  sys_bus_responder #(.ACK_LAT(0)) u_lat0 (
    .sys_clk_i(clk), .sys_rst_i(rst), .sys_addr_i(addr), .sys_wdata_i(wdata),
    .sys_sel_i(sel), .sys_wen_i(wen[0]), .sys_ren_i(ren[0]), .sys_rdata_o(rdata[0]),
    .sys_err_o(err[0]), .sys_ack_o(ack[0]), .cfg_o(cfg[0])
  );

  sys_bus_responder #(.ACK_LAT(3)) u_lat3 (
    .sys_clk_i(clk), .sys_rst_i(rst), .sys_addr_i(addr), .sys_wdata_i(wdata),
    .sys_sel_i(sel), .sys_wen_i(wen[1]), .sys_ren_i(ren[1]), .sys_rdata_o(rdata[1]),
    .sys_err_o(err[1]), .sys_ack_o(ack[1]), .cfg_o(cfg[1])
  );

  sys_bus_responder #(.ACK_LAT(5)) u_lat5 (
    .sys_clk_i(clk), .sys_rst_i(rst), .sys_addr_i(addr), .sys_wdata_i(wdata),
    .sys_sel_i(sel), .sys_wen_i(wen[2]), .sys_ren_i(ren[2]), .sys_rdata_o(rdata[2]),
    .sys_err_o(err[2]), .sys_ack_o(ack[2]), .cfg_o(cfg[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ack seen on any instance, stamped with its edge number
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1) begin
        mon_r.dut   = 2'(d);
        mon_r.rdata = rdata[d];
        mon_r.err   = err[d];
        mon_r.cyc   = 32'(cyc);
        obs_q.push_back(mon_r);
      end
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  // Drive one request pulse (called at a negedge) and queue its expected response
  task automatic issue(input int d, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s,
                       input logic [31:0] xr, input bit xe);
    rsp_t e;
    addr   = a;
    wdata  = wd;
    sel    = s;
    wen[d] = wr;
    ren[d] = rd;
    e.dut   = 2'(d);
    e.rdata = xr;
    e.err   = xe;
    e.cyc   = 32'(cyc + 2 + lat_of(d));
    exp_q.push_back(e);
    @(negedge clk);
    wen[d] = 1'b0;
    ren[d] = 1'b0;
  endtask

  task automatic wait_acks();
    for (int i = 0; i < 60; i++) begin
      if (obs_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic txn(input int d, input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] s,
                     input logic [31:0] xr, input bit xe);
    issue(d, wr, rd, a, wd, s, xr, xe);
    wait_acks();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rsp_t e, o;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({ack[d], err[d], rdata[d], cfg[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs dut %0d got ack %b err %b rdata %h cfg %h, want all zero",
                 d, ack[d], err[d], rdata[d], cfg[d]);
      end
    end
    txn(0, 0, 1, 32'h14, 0, 0, 32'h0, 0);
    txn(0, 0, 1, 32'h1C, 0, 0, 32'h0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL reset_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL reset_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_basic();
    rsp_t e, o;
    do_reset();
    txn(0, 1, 0, 32'h00, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    txn(0, 0, 1, 32'h00, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    txn(0, 1, 0, 32'h04, 32'h1122_3344, 4'hF, 32'h0, 0);
    txn(0, 1, 0, 32'h04, 32'hAABB_CCDD, 4'b0101, 32'h0, 0);
    txn(0, 0, 1, 32'h04, 32'h0, 4'h0, 32'h11BB_33DD, 0);
    vectors++;
    if (cfg[0][63:32] !== 32'h11BB_33DD) begin
      miscompares++; $display("FAIL byte_sel_cfg1 got %h, want 11bb33dd", cfg[0][63:32]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL basic_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL basic_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_errors();
    rsp_t e, o;
    do_reset();
    txn(0, 0, 1, 32'h22, 0, 0, 32'h0, 1);
    txn(0, 0, 1, 32'h40, 0, 0, 32'h0, 1);
    txn(0, 1, 1, 32'h00, 32'h5555_5555, 4'hF, 32'h0, 1);
    txn(0, 1, 0, 32'h01, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    txn(0, 1, 0, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 0);
    txn(0, 0, 1, 32'h18, 0, 0, 32'h0, 0);
    txn(0, 0, 1, 32'h10, 0, 0, 32'h0001_0000, 0);
    txn(0, 0, 1, 32'h14, 0, 0, 32'h1, 0);
    vectors++;
    if (cfg[0][31:0] !== 32'h0) begin
      miscompares++; $display("FAIL error_no_write cfg0 got %h, want 00000000", cfg[0][31:0]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL error_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL error_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_counters();
    rsp_t e, o;
    do_reset();
    txn(0, 1, 0, 32'h08, 32'h1, 4'hF, 32'h0, 0);
    txn(0, 1, 0, 32'h0C, 32'h2, 4'hF, 32'h0, 0);
    txn(0, 1, 0, 32'h00, 32'h3, 4'hF, 32'h0, 0);
    txn(0, 0, 1, 32'h08, 0, 0, 32'h1, 0);
    txn(0, 0, 1, 32'h0C, 0, 0, 32'h2, 0);
    txn(0, 0, 1, 32'h18, 0, 0, 32'h2, 0);
    txn(0, 0, 1, 32'h14, 0, 0, 32'h3, 0);
    txn(0, 1, 0, 32'h1C, 32'h1, 4'hF, 32'h0, 0);
    txn(0, 0, 1, 32'h14, 0, 0, 32'h1, 0);
    txn(0, 0, 1, 32'h18, 0, 0, 32'h1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL counter_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL counter_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e, o;
    do_reset();
    issue(0, 1, 0, 32'h0C, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    @(negedge clk);
    issue(0, 0, 1, 32'h0C, 0, 0, 32'hCAFE_F00D, 0);
    @(negedge clk);
    issue(0, 0, 1, 32'h1C, 0, 0, 32'h0, 0);
    wait_acks();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL b2b_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL b2b_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_latency();
    rsp_t e, o;
    do_reset();
    issue(1, 0, 1, 32'h10, 0, 0, 32'h0001_0000, 0);
    @(negedge clk);
    addr   = 32'h0;
    ren[1] = 1'b1;
    @(negedge clk);
    ren[1] = 1'b0;
    wait_acks();
    txn(1, 0, 1, 32'h1C, 0, 0, 32'h2, 0);
    txn(1, 1, 0, 32'h1C, 32'h2, 4'hF, 32'h0, 0);
    txn(1, 0, 1, 32'h1C, 0, 0, 32'h0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL latency_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL latency_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++; $display("FAIL latency_extra_ack got %0d acks, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    do_reset();
    addr   = 32'h08;
    wdata  = 32'h7777_7777;
    sel    = 4'hF;
    wen[2] = 1'b1;
    @(negedge clk);
    wen[2] = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    ren[2] = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    ren[2] = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++; $display("FAIL reset_mid_ack got %0d acks, want 0", obs_q.size());
      obs_q.delete();
    end
    vectors++;
    if (cfg[2][95:64] !== 32'h0) begin
      miscompares++; $display("FAIL reset_mid_cfg2 got %h, want 00000000", cfg[2][95:64]);
    end
    txn(2, 0, 1, 32'h08, 0, 0, 32'h0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL reset_mid_rsp no ack, want rdata %h err %0d cyc %0d", e.rdata, e.err, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL reset_mid_rsp got dut %0d rdata %h err %0d cyc %0d, want dut %0d rdata %h err %0d cyc %0d",
                   o.dut, o.rdata, o.err, o.cyc, e.dut, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_errors();
    test_counters();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++; $display("FAIL stray_ack got %0d acks, want 0", obs_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish by 500000, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_bus_responder.md
SYS_BUS_RESPONDER -- requirements
Module: sys_bus_responder

Interface
REQ-001 SHALL have parameter AXI_DW, default 32, data width.
REQ-002 SHALL have parameter AXI_AW, default 32, address width.
REQ-003 SHALL have parameter AXI_SW, default AXI_DW>>3, byte-select width.
REQ-004 SHALL have parameter ACK_LAT, default 0, extra wait cycles before ack (0..15).
REQ-005 SHALL have parameter ID_VAL, default 32'h0001_0000, value of the read-only ID register.
REQ-006 SHALL have port sys_clk_i, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port sys_rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port sys_addr_i, input, AXI_AW, request address; offset is addr[19:0].
REQ-009 SHALL have port sys_wdata_i, input, AXI_DW, write data.
REQ-010 SHALL have port sys_sel_i, input, AXI_SW, write byte select.
REQ-011 SHALL have port sys_wen_i, input, 1, one-cycle write request pulse.
REQ-012 SHALL have port sys_ren_i, input, 1, one-cycle read request pulse.
REQ-013 SHALL have port sys_rdata_o, output, AXI_DW, read data.
REQ-014 SHALL have port sys_err_o, output, 1, error flag, valid with ack.
REQ-015 SHALL have port sys_ack_o, output, 1, one-cycle acknowledge pulse.
REQ-016 SHALL have port cfg_o, output, 4*AXI_DW, concatenated CFG0..CFG3 (CFG0 in LSBs).

Function
REQ-017 SHALL map word offsets: 0x00-0x0C CFG0-3 RW; 0x10 ID RO; 0x14 WCNT RO; 0x18 RCNT RO; 0x1C CTRL.
REQ-018 SHALL run FSM IDLE -> WAIT (if ACK_LAT>0) -> RESP -> IDLE; ACK_LAT=0 skips WAIT.
REQ-019 SHALL latch addr, wdata, sel, and type on a request seen in IDLE (cycle N).
REQ-020 SHALL assert sys_ack_o for exactly one cycle, cycle N+1+ACK_LAT, then return to IDLE.
REQ-021 SHALL ignore requests arriving outside IDLE (no ack) and set CTRL bit1 (overrun, sticky).
REQ-022 SHALL treat sys_wen_i and sys_ren_i both high in IDLE as an error transaction: ack+err, no state change.
REQ-023 SHALL flag an error (err=1 with ack, rdata=0, no write) for addr[1:0]!=0 or offset>=0x20.
REQ-024 SHALL commit a CFG write on the edge that raises ack, updating only bytes with sys_sel_i set.
REQ-025 SHALL ack writes to ID/WCNT/RCNT with err=0 and discard the data.
REQ-026 SHALL clear WCNT and RCNT when a write to CTRL has bit0=1, and clear overrun when bit1=1.
REQ-027 SHALL increment WCNT per acked non-error write and RCNT per acked non-error read; 32-bit, wrap 0xFFFFFFFF->0.
REQ-028 SHALL read CTRL as {30'b0, overrun, 1'b0}.
REQ-029 SHALL capture sys_rdata_o on the edge raising ack and hold it until the next ack.
REQ-030 SHALL count the write to CTRL itself after the clear, so WCNT reads 1 afterwards.

Reset
REQ-031 SHALL, with sys_rst_i high at an edge, set FSM=IDLE, ack=0, err=0, rdata=0, CFG0-3=0, WCNT=RCNT=0, overrun=0.
REQ-032 SHALL abandon an in-flight transaction on reset mid-operation: no ack, no write commit.
REQ-033 SHALL ignore requests in the cycle sys_rst_i is high.

Structure
REQ-034 SHALL put the register offsets, CTRL bit positions, and the FSM state enum in shared package sys_bus_pkg.
REQ-035 SHALL implement the single sub-module sys_bus_wait_cnt (4-bit load/decrement counter, done flag) for the WAIT state.

Verification
REQ-036 SHALL: ACK_LAT=0, write 0x00=0xDEADBEEF with sel=4'hF, then read 0x00 -> ack 1 cycle after each request, rdata=0xDEADBEEF, err=0.
REQ-037 SHALL: write 0x04=0x11223344 sel=4'hF, then 0x04=0xAABBCCDD sel=4'b0101 -> CFG1=0x11BB33DD.
REQ-038 SHALL: ACK_LAT=3, read 0x10 -> ack in cycle N+4, rdata=0x00010000; second ren at N+2 -> no extra ack, CTRL reads 0x2.
REQ-039 SHALL: read 0x22 and read 0x40 -> each ack with err=1, rdata=0; RCNT unchanged.
REQ-040 SHALL: 3 writes, 2 reads, then read 0x14/0x18 -> 3 and 2; write CTRL=0x1 -> WCNT=1, RCNT=1 after the following read.
REQ-041 SHALL: ACK_LAT=5, reset at N+2 of a write to 0x08 -> no ack, CFG2=0.
